ct_wrr_merge: RTL and testbench

CT_WRR_MERGE -- requirements
Module: ct_wrr_merge

---
 rtl/ct_wrr_merge.sv | 73 +++++++
 tb/tb_ct_wrr_merge.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ct_wrr_merge.sv
// ct_wrr_merge: weighted round-robin packet merge of NI streams into one registered output.
// Packets are never interleaved; each input gets i_weight packets per turn (0 counts as 1).
module ct_wrr_merge #(
   parameter int NI    = 2,
   parameter int WIDTH = 8,
   parameter int WBITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NI*WIDTH-1:0]   i_data,
   input  logic [NI-1:0]         i_valid,
   input  logic [NI-1:0]         i_eop,
   output logic [NI-1:0]         o_ready,
   input  logic [NI*WBITS-1:0]   i_weight,
   output logic [WIDTH-1:0]      o_data,
   output logic                  o_valid,
   output logic                  o_eop,
   input  logic                  i_ready,
   output logic [$clog2(NI)-1:0] o_grant
);
   localparam int NIBITS = $clog2(NI);
   typedef enum logic {S_IDLE, S_LOCKED} state_t;
   state_t            state;
   logic [NIBITS-1:0] prio_ptr, lock_idx, scan, cur, nxt_ptr;
   logic [WBITS-1:0]  pkt_cnt, w, eff_w;
   logic [WBITS:0]    n;
   logic              load, xfer, done, wrap;
   int                j;
   // descending scan so the lowest offset from prio_ptr wins
   always_comb begin
      scan = prio_ptr;
      j = 0;
      for (int k = NI-1; k >= 0; k--) begin
         j = int'(prio_ptr) + k;
         j = j >= NI ? j - NI : j;
         scan = i_valid[NIBITS'(j)] ? NIBITS'(j) : scan;
      end
   end
   assign cur     = state == S_LOCKED ? lock_idx : scan;
   assign o_grant = cur;
   assign load    = !o_valid || i_ready;
   assign o_ready = load ? NI'(1) << cur : '0;
   assign xfer    = load && i_valid[cur];
   assign done    = xfer && i_eop[cur];
   assign w       = i_weight[int'(cur)*WBITS +: WBITS];
   assign eff_w   = w == '0 ? WBITS'(1) : w;
   assign n       = (cur == prio_ptr ? {1'b0, pkt_cnt} : '0) + 1'b1;
   assign wrap    = n >= {1'b0, eff_w};
   assign nxt_ptr = int'(cur) == NI-1 ? '0 : cur + 1'b1;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         prio_ptr <= '0;
         pkt_cnt  <= '0;
         lock_idx <= '0;
         o_valid  <= 1'b0;
         o_eop    <= 1'b0;
         o_data   <= '0;
      end else begin
         if (load) o_valid <= xfer;
         if (xfer) begin
            o_data   <= i_data[int'(cur)*WIDTH +: WIDTH];
            o_eop    <= i_eop[cur];
            state    <= i_eop[cur] ? S_IDLE : S_LOCKED;
            lock_idx <= cur;
         end
         if (done) begin
            prio_ptr <= wrap ? nxt_ptr : cur;
            pkt_cnt  <= wrap ? '0 : n[WBITS-1:0];
         end
      end
   end
endmodule

// File: tb/tb_ct_wrr_merge.sv
// tb_ct_wrr_merge: directed and randomized checks of ct_wrr_merge against a cycle reference model.
module tb_ct_wrr_merge;
   localparam int NI = 3, W = 8, WB = 2;
   logic clk = 1'b0, reset = 1'b0;
   logic [NI*W-1:0]  i_data = '0;
   logic [NI-1:0]    i_valid = '0, i_eop = '0, o_ready;
   logic [NI*WB-1:0] i_weight = '0;
   logic [W-1:0]     o_data;
   logic             o_valid, o_eop, i_ready = 1'b1;
   logic [1:0]       o_grant;
   int checks = 0, errors = 0;
   int m_turn, m_used, m_lock;
   logic m_ov, m_oe;
   logic [W-1:0] m_od, frz;
   logic xf;
   int xg;
   int hist[$], expq[$];
   int pend[NI], rem[NI], seq[NI], pkts[NI];
   logic drv_en, rdy_rand;
   int p_on, maxlen;
   int t3v[8] = '{1, 1, 1, 0, 0, 1, 1, 0};
   int t3d[8] = '{'hB1, 'hB1, 'hB2, 0, 0, 'hB3, 'hB4, 0};
   int t3e[8] = '{0, 0, 0, 0, 0, 0, 1, 0};

   ct_wrr_merge #(.NI(NI), .WIDTH(W), .WBITS(WB)) dut (
      .clk(clk), .reset(reset), .i_data(i_data), .i_valid(i_valid), .i_eop(i_eop),
      .o_ready(o_ready), .i_weight(i_weight), .o_data(o_data), .o_valid(o_valid),
      .o_eop(o_eop), .i_ready(i_ready), .o_grant(o_grant));

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_hist(string tag);
      check({tag, "_count"}, hist.size(), expq.size());
      for (int k = 0; k < expq.size() && k < hist.size(); k++) check(tag, hist[k], expq[k]);
   endtask

   function automatic int exp_grant();
      if (m_lock >= 0) return m_lock;
      for (int k = 0; k < NI; k++) if (i_valid[(m_turn + k) % NI]) return (m_turn + k) % NI;
      return m_turn;
   endfunction

   task automatic set_in(int i, logic v, logic e, logic [W-1:0] d);
      i_valid[i] = v;
      i_eop[i] = e;
      i_data[i*W +: W] = d;
   endtask

   task automatic src_init(int npk);
      for (int i = 0; i < NI; i++) begin
         pend[i] = 0; rem[i] = 0; seq[i] = 0; pkts[i] = npk;
         set_in(i, 1'b0, 1'b0, '0);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NI; i++) begin
         if (xf && xg == i) begin pend[i] = 0; rem[i]--; end
         if (drv_en) begin
            if (pend[i] == 0 && (rem[i] > 0 || pkts[i] > 0) && $urandom_range(99) < p_on) begin
               if (rem[i] == 0) begin rem[i] = $urandom_range(maxlen, 1); pkts[i]--; end
               set_in(i, 1'b1, rem[i] == 1, {2'(i), 6'(seq[i])});
               seq[i]++;
               pend[i] = 1;
            end
            i_valid[i] = pend[i] != 0;
         end
      end
      if (rdy_rand) i_ready = $urandom_range(99) < 70;
   endtask

   task automatic tick();
      int g, w, n;
      logic ld;
      @(negedge clk);
      g = exp_grant();
      ld = !m_ov || i_ready;
      check("grant", o_grant, g);
      check("ready", o_ready, ld ? (1 << g) : 0);
      check("ovalid", o_valid, m_ov);
      if (m_ov) begin
         check("odata", o_data, m_od);
         check("oeop", o_eop, m_oe);
      end
      xf = ld && i_valid[g];
      xg = g;
      if (xf) begin
         hist.push_back(g);
         m_ov = 1'b1;
         m_od = i_data[g*W +: W];
         m_oe = i_eop[g];
         if (i_eop[g]) begin
            w = int'(i_weight[g*WB +: WB]);
            if (w == 0) w = 1;
            n = (g == m_turn ? m_used : 0) + 1;
            if (n >= w) begin m_turn = (g + 1) % NI; m_used = 0; end
            else begin m_turn = g; m_used = n; end
            m_lock = -1;
         end else m_lock = g;
      end else if (ld) m_ov = 1'b0;
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      m_ov = 1'b0; m_od = '0; m_oe = 1'b0; m_turn = 0; m_used = 0; m_lock = -1; xf = 1'b0;
      @(negedge clk);
      check("rst_ovalid", o_valid, 0);
      check("rst_odata", o_data, 0);
      check("rst_oeop", o_eop, 0);
      check("rst_grant", o_grant, exp_grant());
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      drv_en = 1'b1; rdy_rand = 1'b0; p_on = 100; maxlen = 1; xf = 1'b0; xg = 0;
      // equal weights, continuous single-beat packets
      i_weight = {2'd1, 2'd1, 2'd1};
      src_init(1000);
      do_reset();
      check("idle_ready", o_ready, 3'b001);
      drive();
      hist.delete();
      repeat (6) tick();
      expq = {0, 1, 2, 0, 1, 2};
      check_hist("rr_equal");
      repeat (3) begin
         tick();
         check("ovalid_cont", o_valid, 1);
      end
      // weights {3,1,2}
      i_weight = {2'd2, 2'd1, 2'd3};
      src_init(1000);
      do_reset();
      drive();
      hist.delete();
      repeat (9) tick();
      expq = {0, 0, 0, 1, 2, 2, 0, 0, 0};
      check_hist("wrr_312");
      // lock held across input bubbles
      drv_en = 1'b0;
      i_weight = {2'd1, 2'd1, 2'd1};
      src_init(0);
      do_reset();
      hist.delete();
      for (int k = 0; k < 8; k++) begin
         set_in(0, 1'b1, 1'b1, k == 0 ? 8'hA0 : 8'hA1);
         set_in(1, 1'(t3v[k]), 1'(t3e[k]), 8'(t3d[k]));
         tick();
         if (k >= 1 && k <= 5) begin
            check("lock_grant", o_grant, 1);
            check("lock_ready0", o_ready[0], 0);
         end
      end
      expq = {0, 1, 1, 1, 1, 0};
      check_hist("lock_seq");
      // zero weights behave as one, with downstream stall
      drv_en = 1'b1;
      i_weight = '0;
      src_init(1000);
      do_reset();
      drive();
      hist.delete();
      repeat (6) tick();
      frz = m_od;
      i_ready = 1'b0;
      repeat (3) begin
         tick();
         check("stall_data", o_data, frz);
         check("stall_ready", o_ready, 0);
         check("stall_valid", o_valid, 1);
      end
      i_ready = 1'b1;
      repeat (6) tick();
      expq = {0, 1, 2, 0, 1, 2, 0, 1, 2, 0, 1, 2};
      check_hist("zero_w");
      // reset while locked on input 2
      drv_en = 1'b0;
      i_weight = {2'd1, 2'd1, 2'd1};
      src_init(0);
      do_reset();
      hist.delete();
      set_in(2, 1'b1, 1'b0, 8'hC1);
      tick();
      set_in(2, 1'b1, 1'b0, 8'hC2);
      set_in(0, 1'b1, 1'b1, 8'hA0);
      tick();
      check("locked_ready0", o_ready[0], 0);
      set_in(2, 1'b1, 1'b0, 8'hC3);
      do_reset();
      check("post_rst_grant", o_grant, 0);
      check("post_rst_ready", o_ready, 3'b001);
      tick();
      set_in(0, 1'b0, 1'b0, 8'h00);
      set_in(2, 1'b1, 1'b1, 8'hC4);
      tick();
      expq = {2, 2, 0, 2};
      check_hist("rst_lock");
      // forfeited turn restarts the count for the next input
      drv_en = 1'b1;
      i_weight = {2'd2, 2'd2, 2'd2};
      src_init(1000);
      pkts[0] = 1;
      do_reset();
      drive();
      hist.delete();
      repeat (7) tick();
      expq = {0, 1, 1, 2, 2, 1, 1};
      check_hist("forfeit");
      // randomized traffic, multi-beat packets, random backpressure
      p_on = 60; maxlen = 4; rdy_rand = 1'b1;
      src_init(100000);
      do_reset();
      drive();
      for (int ph = 0; ph < 4; ph++) begin
         i_weight = 6'($urandom);
         repeat (500) tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
